// File: rtl/ofdm_pkg.sv
// Shared constants, FSM state type and the subcarrier/slot map for the
// OFDM subcarrier assembler.
package ofdm_pkg;

  localparam int         NUM_SC     = 8;
  localparam int         NUM_SLOTS  = 5;
  localparam logic [2:0] NULL_IDX   = 3'd0;
  localparam logic [2:0] PILOT_IDX0 = 3'd2;
  localparam logic [2:0] PILOT_IDX1 = 3'd6;
  localparam logic [2:0] LAST_IDX   = 3'd7;
  localparam logic [2:0] FULL_CNT   = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_EMIT = 2'd2
  } state_e;

  // Data slot that feeds a given subcarrier; non-data subcarriers map to 0.
  function automatic logic [2:0] sc_to_slot(input logic [2:0] sc);
    logic [2:0] slot;
    case (sc)
      3'd1:    slot = 3'd0;
      3'd3:    slot = 3'd1;
      3'd4:    slot = 3'd2;
      3'd5:    slot = 3'd3;
      3'd7:    slot = 3'd4;
      default: slot = 3'd0;
    endcase
    return slot;
  endfunction

  // True for subcarriers that carry user data.
  function automatic logic sc_is_data(input logic [2:0] sc);
    logic is_data;
    case (sc)
      3'd1, 3'd3, 3'd4, 3'd5, 3'd7: is_data = 1'b1;
      default:                      is_data = 1'b0;
    endcase
    return is_data;
  endfunction

endpackage

// File: rtl/ofdm_frame_buf.sv
// 5x8 data slot register file: one write port, one combinational read
// port, and a synchronous clear of all slots.
module ofdm_frame_buf
  import ofdm_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       we,
  input  logic [2:0] waddr,
  input  logic [7:0] wdata,
  input  logic [2:0] raddr,
  output logic [7:0] rdata
);

  logic [7:0] slot_q [NUM_SLOTS];
  logic [7:0] slot_d [NUM_SLOTS];

  // Next slot contents: clear wins over a write; out-of-range writes dropped.
  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      slot_d[i] = slot_q[i];
    end
    if (clr) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_d[i] = 8'h00;
      end
    end else if (we && (waddr < FULL_CNT)) begin
      slot_d[waddr] = wdata;
    end else begin
      slot_d[0] = slot_q[0];
    end
  end

  // Read port; out-of-range addresses read as zero.
  always_comb begin
    rdata = 8'h00;
    if (raddr < FULL_CNT) begin
      rdata = slot_q[raddr];
    end else begin
      rdata = 8'h00;
    end
  end

  // Slot storage with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_q[i] <= 8'h00;
      end
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_q[i] <= slot_d[i];
      end
    end
  end

endmodule

// File: rtl/ofdm_subcarrier_assembler.sv
// Collects five mapped data symbols, then emits an 8-subcarrier OFDM frame
// with a null at index 0 and pilots at indices 2 and 6.
module ofdm_subcarrier_assembler
  import ofdm_pkg::*;
#(
  parameter logic signed [3:0] PILOT_AMP    = 4'sd1,
  parameter bit                PILOT_TOGGLE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sym_in,
  input  logic       sym_valid,
  output logic       sym_ready,
  input  logic       flush,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_first,
  output logic       out_last,
  output logic [7:0] frame_count,
  output logic       busy
);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] fc_q, fc_d;
  logic [7:0] out_data_q, out_data_d;
  logic       out_valid_q, out_valid_d;
  logic       out_first_q, out_first_d;
  logic       out_last_q, out_last_d;
  logic       busy_q, busy_d;

  logic             accept;
  logic [2:0]       cnt_after;
  logic             buf_we;
  logic             buf_clr;
  logic [2:0]       buf_raddr;
  logic [7:0]       buf_rdata;
  logic signed [3:0] pilot_i;

  assign sym_ready = (state_q != ST_EMIT);
  assign accept    = sym_valid && sym_ready;

  // Slots hold zero between frames (cleared at frame end and on reset), so a
  // flush needs no extra writes to zero the slots that were never filled.
  ofdm_frame_buf u_buf (
    .clk   (clk),
    .rst   (rst),
    .clr   (buf_clr),
    .we    (buf_we),
    .waddr (cnt_q),
    .wdata (sym_in),
    .raddr (buf_raddr),
    .rdata (buf_rdata)
  );

  // FSM next state: accept is applied before flush on the same edge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    fc_d      = fc_q;
    buf_we    = 1'b0;
    buf_clr   = 1'b0;
    cnt_after = cnt_q;
    case (state_q)
      ST_IDLE, ST_FILL: begin
        if (accept) begin
          buf_we    = 1'b1;
          cnt_after = cnt_q + 3'd1;
        end else begin
          cnt_after = cnt_q;
        end
        cnt_d = cnt_after;
        if (cnt_after == FULL_CNT) begin
          state_d = ST_EMIT;
          idx_d   = NULL_IDX;
        end else if (flush && (cnt_after != 3'd0)) begin
          state_d = ST_EMIT;
          idx_d   = NULL_IDX;
        end else if (cnt_after != 3'd0) begin
          state_d = ST_FILL;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EMIT: begin
        if (out_valid_q && out_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_IDLE;
            cnt_d   = 3'd0;
            idx_d   = NULL_IDX;
            fc_d    = fc_q + 8'd1;
            buf_clr = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          idx_d = idx_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 3'd0;
        idx_d   = NULL_IDX;
      end
    endcase
  end

  // Output mux evaluated on next-state values so outputs are registered yet
  // show subcarrier 0 one cycle after the frame closes; pilots are built here.
  always_comb begin
    out_valid_d = 1'b0;
    out_first_d = 1'b0;
    out_last_d  = 1'b0;
    out_data_d  = 8'h00;
    busy_d      = (state_d != ST_IDLE);
    buf_raddr   = sc_to_slot(idx_d);
    pilot_i     = (PILOT_TOGGLE && fc_d[0]) ? -PILOT_AMP : PILOT_AMP;
    if (state_d == ST_EMIT) begin
      out_valid_d = 1'b1;
      out_first_d = (idx_d == NULL_IDX);
      out_last_d  = (idx_d == LAST_IDX);
      if ((idx_d == PILOT_IDX0) || (idx_d == PILOT_IDX1)) begin
        out_data_d = {4'h0, pilot_i};
      end else if (sc_is_data(idx_d)) begin
        out_data_d = buf_rdata;
      end else begin
        out_data_d = 8'h00;
      end
    end else begin
      out_valid_d = 1'b0;
    end
  end

  // State, counters and registered outputs with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      idx_q       <= NULL_IDX;
      fc_q        <= 8'd0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      fc_q        <= fc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
    end
  end

  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign out_first   = out_first_q;
  assign out_last    = out_last_q;
  assign frame_count = fc_q;
  assign busy        = busy_q;

endmodule
